// File: rtl/pwrseq_master_seq.sv
// -----------------------------------------------------------------------------
// pwrseq_master_seq
// Master power sequencer for NUM_STG slave stages. Stages are brought up one at
// a time, and each stage's power-good must arrive within TMO_MS ticks. They are
// taken down in reverse order, with DLY_MS ticks between stages. A slave fault
// or a power-good timeout latches the stage(s) involved and parks the sequencer
// in CRIT until software clears it.
//
// Ports
//   clk, reset        system clock; asynchronous active-high reset
//   t1ms              one-clk tick every millisecond
//   pwr_on_req        level request: power up (honoured in OFF only)
//   pwr_off_req       level request: power down (honoured in PWRUP/ON)
//   clr_fault_req     level request: leave CRIT
//   stg_pgd_so_far    per-stage cumulative power-good
//   stg_mod_fault     per-stage fault
//   stg_gate_en       per-stage gate enable (registered)
//   chklive_en/chklive_dis/pwrdis_en/sm_critical_fail/fault_clear/
//   any_pwr_fault_det broadcast slave controls (registered)
//   fault_stg         latched stage(s) that caused the critical fail
//   pwr_state         OFF=0 PWRUP=1 ON=2 PWRDN=3 CRIT=4
// -----------------------------------------------------------------------------
module pwrseq_master_seq #(
    parameter int NUM_STG = 4,
    parameter int TMO_MS  = 100,
    parameter int DLY_MS  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               t1ms,
    input  logic               pwr_on_req,
    input  logic               pwr_off_req,
    input  logic               clr_fault_req,
    input  logic [NUM_STG-1:0] stg_pgd_so_far,
    input  logic [NUM_STG-1:0] stg_mod_fault,
    output logic [NUM_STG-1:0] stg_gate_en,
    output logic               chklive_en,
    output logic               chklive_dis,
    output logic               pwrdis_en,
    output logic               sm_critical_fail,
    output logic               fault_clear,
    output logic               any_pwr_fault_det,
    output logic [NUM_STG-1:0] fault_stg,
    output logic [2:0]         pwr_state
);

    localparam int TMAX_MS = (TMO_MS > DLY_MS) ? TMO_MS : DLY_MS;
    localparam int TW      = $clog2(TMAX_MS + 1);
    localparam int IW      = (NUM_STG > 1) ? $clog2(NUM_STG) : 1;

    localparam logic [TW-1:0] TMO  = TW'(TMO_MS);
    localparam logic [TW-1:0] DLY  = TW'(DLY_MS);
    localparam logic [TW-1:0] TSAT = {TW{1'b1}};
    localparam logic [IW-1:0] LAST = IW'(NUM_STG - 1);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_PWRUP = 3'd1,
        S_ON    = 3'd2,
        S_PWRDN = 3'd3,
        S_CRIT  = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [IW-1:0]      idx, idx_n;
    logic [TW-1:0]      tmr, tmr_n, tmr_inc;
    logic [NUM_STG-1:0] gate_n, fstg_n, act_flt;
    logic               fclr_n;

    // Saturating tick counter: it holds at all-ones instead of wrapping.
    assign tmr_inc = (tmr == TSAT) ? tmr : tmr + 1'b1;

    // Faults count only from stages whose gate is currently enabled.
    assign act_flt = stg_mod_fault & stg_gate_en;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        tmr_n   = tmr;
        gate_n  = stg_gate_en;
        fstg_n  = fault_stg;
        fclr_n  = 1'b0;
        case (state)
            S_OFF: begin
                gate_n = '0;
                if (pwr_on_req) begin
                    state_n = S_PWRUP;
                    idx_n   = '0;
                    tmr_n   = '0;
                    gate_n  = NUM_STG'(1);
                end
            end
            S_PWRUP, S_ON: begin
                if (t1ms && state == S_PWRUP)
                    tmr_n = tmr_inc;
                // Priority: slave fault > timeout > off request > advance.
                // Because the timeout branch requires pgd low, a pgd that
                // arrives on the timeout cycle advances the stage.
                if (|act_flt) begin
                    state_n = S_CRIT;
                    fstg_n  = fault_stg | act_flt;
                end else if (state == S_PWRUP && !stg_pgd_so_far[idx] && tmr >= TMO) begin
                    state_n     = S_CRIT;
                    fstg_n[idx] = 1'b1;
                end else if (pwr_off_req) begin
                    state_n = S_PWRDN;
                    tmr_n   = '0;
                end else if (state == S_PWRUP && stg_pgd_so_far[idx]) begin
                    tmr_n = '0;
                    if (idx == LAST) begin
                        state_n = S_ON;
                    end else begin
                        idx_n         = idx + 1'b1;
                        gate_n[idx_n] = 1'b1;
                    end
                end
            end
            S_PWRDN: begin
                // Faults and on requests are deliberately ignored, so that
                // shutdown always completes.
                if (tmr >= DLY) begin
                    gate_n[idx] = 1'b0;
                    tmr_n       = '0;
                    if (idx == '0)
                        state_n = S_OFF;
                    else
                        idx_n = idx - 1'b1;
                end else if (t1ms) begin
                    tmr_n = tmr_inc;
                end
            end
            S_CRIT: begin
                // The gates drop on the first clock spent in CRIT.
                gate_n = '0;
                if (clr_fault_req) begin
                    state_n = S_OFF;
                    fclr_n  = 1'b1;
                    fstg_n  = '0;
                    idx_n   = '0;
                    tmr_n   = '0;
                end
            end
            default: begin
                state_n = S_OFF;
                gate_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_OFF;
            idx               <= '0;
            tmr               <= '0;
            stg_gate_en       <= '0;
            fault_stg         <= '0;
            fault_clear       <= 1'b0;
            chklive_en        <= 1'b0;
            chklive_dis       <= 1'b1;
            pwrdis_en         <= 1'b0;
            sm_critical_fail  <= 1'b0;
            any_pwr_fault_det <= 1'b0;
        end else begin
            state             <= state_n;
            idx               <= idx_n;
            tmr               <= tmr_n;
            stg_gate_en       <= gate_n;
            fault_stg         <= fstg_n;
            fault_clear       <= fclr_n;
            chklive_en        <= (state_n == S_ON);
            chklive_dis       <= (state_n == S_OFF) || (state_n == S_PWRDN);
            pwrdis_en         <= (state_n == S_CRIT);
            sm_critical_fail  <= (state_n == S_CRIT);
            any_pwr_fault_det <= (state_n == S_CRIT);
        end
    end

    assign pwr_state = state;

endmodule

// File: tb/tb_pwrseq_master_seq.sv
// -----------------------------------------------------------------------------
// tb_pwrseq_master_seq
// Directed bench for pwrseq_master_seq with NUM_STG=4, TMO_MS=100 and
// DLY_MS=10. A simple slave model raises power-good 2 ticks after a stage's
// gate enable. Any stage can be held off by setting blk. When man is set,
// pgd_man drives power-good directly.
// -----------------------------------------------------------------------------
module tb_pwrseq_master_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       t1ms = 1'b0;
    logic       pwr_on_req = 1'b0;
    logic       pwr_off_req = 1'b0;
    logic       clr_fault_req = 1'b0;
    logic [3:0] stg_pgd_so_far;
    logic [3:0] stg_mod_fault = 4'b0;
    logic [3:0] stg_gate_en;
    logic       chklive_en, chklive_dis, pwrdis_en, sm_critical_fail;
    logic       fault_clear, any_pwr_fault_det;
    logic [3:0] fault_stg;
    logic [2:0] pwr_state;

    logic [3:0] blk = 4'b0;
    logic       man = 1'b0;
    logic [3:0] pgd_man = 4'b0;
    logic [1:0] cnt [4];
    logic [3:0] pgd_mdl;

    int nchk = 0;
    int npass = 0;

    pwrseq_master_seq #(.NUM_STG(4), .TMO_MS(100), .DLY_MS(10)) dut (
        .clk              (clk),
        .reset            (reset),
        .t1ms             (t1ms),
        .pwr_on_req       (pwr_on_req),
        .pwr_off_req      (pwr_off_req),
        .clr_fault_req    (clr_fault_req),
        .stg_pgd_so_far   (stg_pgd_so_far),
        .stg_mod_fault    (stg_mod_fault),
        .stg_gate_en      (stg_gate_en),
        .chklive_en       (chklive_en),
        .chklive_dis      (chklive_dis),
        .pwrdis_en        (pwrdis_en),
        .sm_critical_fail (sm_critical_fail),
        .fault_clear      (fault_clear),
        .any_pwr_fault_det(any_pwr_fault_det),
        .fault_stg        (fault_stg),
        .pwr_state        (pwr_state)
    );

    always #5 clk = ~clk;

    // Slave model: the tick count saturates at 2 while the gate is on.
    always_ff @(posedge clk or posedge reset) begin
        for (int j = 0; j < 4; j++) begin
            if (reset || !stg_gate_en[j])
                cnt[j] <= 2'd0;
            else if (t1ms && cnt[j] != 2'd2)
                cnt[j] <= cnt[j] + 2'd1;
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++)
            pgd_mdl[j] = stg_gate_en[j] && (cnt[j] == 2'd2) && !blk[j];
    end

    assign stg_pgd_so_far = man ? pgd_man : pgd_mdl;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp)
            npass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        t1ms = 1'b1;
        cyc();
        t1ms = 1'b0;
        cyc();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    logic [3:0] up_gate [4] = '{4'b0011, 4'b0111, 4'b1111, 4'b1111};
    logic [3:0] dn_gate [4] = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};

    initial begin
        // Reset values
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("rst_state", 32'(pwr_state), 32'd0);
        chk("rst_gate", 32'(stg_gate_en), 32'h0);
        chk("rst_dis", 32'(chklive_dis), 32'd1);
        chk("rst_en", 32'(chklive_en), 32'd0);
        chk("rst_fstg", 32'(fault_stg), 32'h0);
        chk("off_ignore", 32'(pwr_state), 32'd0);

        // Power-up: pgd follows each gate by 2 ticks
        pwr_on_req = 1'b1;
        cyc();
        chk("up_state", 32'(pwr_state), 32'd1);
        chk("up_gate0", 32'(stg_gate_en), 32'h1);
        for (int s = 0; s < 4; s++) begin
            ticks(2);
            chk($sformatf("up_gate%0d", s + 1), 32'(stg_gate_en), 32'(up_gate[s]));
        end
        pwr_on_req = 1'b0;
        chk("on_state", 32'(pwr_state), 32'd2);
        chk("on_chklive_en", 32'(chklive_en), 32'd1);
        chk("on_chklive_dis", 32'(chklive_dis), 32'd0);

        // Power-down: stages drop 10 ticks apart, highest stage first
        pwr_off_req = 1'b1;
        cyc();
        pwr_off_req = 1'b0;
        chk("dn_state", 32'(pwr_state), 32'd3);
        chk("dn_dis", 32'(chklive_dis), 32'd1);
        ticks(9);
        chk("dn_hold9", 32'(stg_gate_en), 32'hF);
        tick();
        chk("dn_gate0", 32'(stg_gate_en), 32'(dn_gate[0]));
        for (int s = 1; s < 4; s++) begin
            ticks(10);
            chk($sformatf("dn_gate%0d", s), 32'(stg_gate_en), 32'(dn_gate[s]));
        end
        chk("dn_off", 32'(pwr_state), 32'd0);
        chk("dn_off_dis", 32'(chklive_dis), 32'd1);

        // Stage 2 power-good never arrives, so the stage times out at tick 100
        blk = 4'b0100;
        pwr_on_req = 1'b1;
        cyc();
        pwr_on_req = 1'b0;
        ticks(4);
        chk("to_gate", 32'(stg_gate_en), 32'h7);
        ticks(99);
        chk("to_pre", 32'(pwr_state), 32'd1);
        tick();
        chk("to_state", 32'(pwr_state), 32'd4);
        chk("to_fstg", 32'(fault_stg), 32'h4);
        chk("to_crit", 32'(sm_critical_fail), 32'd1);
        chk("to_pwrdis", 32'(pwrdis_en), 32'd1);
        chk("to_anyflt", 32'(any_pwr_fault_det), 32'd1);
        cyc();
        chk("to_gate_off", 32'(stg_gate_en), 32'h0);
        clr_fault_req = 1'b1;
        cyc();
        clr_fault_req = 1'b0;
        chk("to_clr_state", 32'(pwr_state), 32'd0);
        chk("to_clr_pulse", 32'(fault_clear), 32'd1);
        chk("to_clr_fstg", 32'(fault_stg), 32'h0);
        cyc();
        chk("to_clr_once", 32'(fault_clear), 32'd0);
        blk = 4'b0;

        // A fault in ON takes priority over pwr_off_req in the same cycle
        pwr_on_req = 1'b1;
        cyc();
        pwr_on_req = 1'b0;
        ticks(8);
        chk("f_on", 32'(pwr_state), 32'd2);
        stg_mod_fault = 4'b0010;
        pwr_off_req = 1'b1;
        cyc();
        stg_mod_fault = 4'b0;
        chk("f_state", 32'(pwr_state), 32'd4);
        chk("f_fstg", 32'(fault_stg), 32'h2);
        cyc();
        chk("f_off_ignored", 32'(pwr_state), 32'd4);
        pwr_off_req = 1'b0;
        clr_fault_req = 1'b1;
        cyc();
        clr_fault_req = 1'b0;
        chk("f_clr_pulse", 32'(fault_clear), 32'd1);
        chk("f_clr_state", 32'(pwr_state), 32'd0);
        cyc();
        chk("f_clr_once", 32'(fault_clear), 32'd0);

        // Stage 1 power-good arrives on the timeout cycle, so the stage advances
        man = 1'b1;
        pgd_man = 4'b0000;
        pwr_on_req = 1'b1;
        cyc();
        pwr_on_req = 1'b0;
        pgd_man = 4'b0001;
        cyc();
        chk("co_gate1", 32'(stg_gate_en), 32'h3);
        ticks(99);
        t1ms = 1'b1;
        cyc();
        t1ms = 1'b0;
        pgd_man = 4'b0011;
        cyc();
        chk("co_state", 32'(pwr_state), 32'd1);
        chk("co_gate2", 32'(stg_gate_en), 32'h7);
        chk("co_fstg", 32'(fault_stg), 32'h0);

        // Run up to ON, enter PWRDN, then reset asynchronously mid-cycle
        pgd_man = 4'b1111;
        cyc(); cyc();
        chk("rd_on", 32'(pwr_state), 32'd2);
        pwr_off_req = 1'b1;
        cyc();
        pwr_off_req = 1'b0;
        pwr_on_req = 1'b1;
        cyc();
        pwr_on_req = 1'b0;
        chk("rd_on_ignored", 32'(pwr_state), 32'd3);
        ticks(3);
        chk("rd_gate", 32'(stg_gate_en), 32'hF);
        #2 reset = 1'b1;
        #1;
        chk("rd_state", 32'(pwr_state), 32'd0);
        chk("rd_gate0", 32'(stg_gate_en), 32'h0);
        chk("rd_dis", 32'(chklive_dis), 32'd1);
        chk("rd_crit", 32'(sm_critical_fail), 32'd0);
        chk("rd_en", 32'(chklive_en), 32'd0);
        chk("rd_fclr", 32'(fault_clear), 32'd0);
        reset = 1'b0;
        man = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
